// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the function-unit request side and the registered CDB
// broadcast side of the Common Data Bus arbiter.
//   fu_req     FU -> arb   per-FU result request
//   fu_rob_id  FU -> arb   per-FU ROB tag, FU i at [i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]
//   fu_data    FU -> arb   per-FU result, FU i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fu_gnt     arb -> FU   one-hot grant, combinational
//   rob_flush  ROB -> arb  pipeline flush
//   cdb_*      arb -> listeners, registered broadcast (valid, rob_id, data, one-hot src)
// Modports: master = requester/listener side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int unsigned REQ_NUM        = 4,
   parameter int unsigned ROB_ENTRY      = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) ();

   logic [REQ_NUM-1:0]                fu_req;
   logic [REQ_NUM*ROB_ENTRY_LOG2-1:0] fu_rob_id;
   logic [REQ_NUM*DATA_WIDTH-1:0]     fu_data;
   logic [REQ_NUM-1:0]                fu_gnt;
   logic                              rob_flush;
   logic                              cdb_valid;
   logic [ROB_ENTRY_LOG2-1:0]         cdb_rob_id;
   logic [DATA_WIDTH-1:0]             cdb_data;
   logic [REQ_NUM-1:0]                cdb_src;

   modport master (
      output fu_req, fu_rob_id, fu_data, rob_flush,
      input  fu_gnt, cdb_valid, cdb_rob_id, cdb_data, cdb_src
   );

   modport slave (
      input  fu_req, fu_rob_id, fu_data, rob_flush,
      output fu_gnt, cdb_valid, cdb_rob_id, cdb_data, cdb_src
   );

endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the single Common Data Bus between the
// function units (0=ALU, 1=LSU, 2=BPU, 3=CSR). One request is granted per cycle with a
// combinational one-hot fu_gnt; the winner's tag/data are broadcast on a registered CDB
// stage one cycle later.
// Ports:
//   CLK   clock, rising edge
//   RSTN  asynchronous active-low reset
//   bus   cdb_arbiter_if.slave (requests, grants, flush, CDB broadcast)
// Configuration macro:
//   CDB_ARB_BPU_PRIO_EN  when defined, a BPU request (index 2) wins unconditionally and
//                        does not advance the round-robin pointer.
module cdb_arbiter #(
   parameter int unsigned REQ_NUM        = 4,
   parameter int unsigned ROB_ENTRY      = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) (
   input logic          CLK,
   input logic          RSTN,
   cdb_arbiter_if.slave bus
);

   localparam int unsigned PtrW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

`ifdef CDB_ARB_BPU_PRIO_EN
   localparam logic [PtrW-1:0] BpuIdx = PtrW'(2);
`endif

   logic [PtrW-1:0]           rr_ptr_q, rr_ptr_d;
   logic                      cdb_valid_q, cdb_valid_d;
   logic [ROB_ENTRY_LOG2-1:0] cdb_rob_id_q, cdb_rob_id_d;
   logic [DATA_WIDTH-1:0]     cdb_data_q, cdb_data_d;
   logic [REQ_NUM-1:0]        cdb_src_q, cdb_src_d;

   logic                      found;
   logic                      prio_win;
   logic                      grant;
   logic [PtrW-1:0]           winner;
   logic [PtrW-1:0]           idx;
   logic [REQ_NUM-1:0]        gnt;
   logic [ROB_ENTRY_LOG2-1:0] win_rob_id;
   logic [DATA_WIDTH-1:0]     win_data;

   // Winner selection: first set request scanning from rr_ptr with wrap.
   always_comb begin
      found    = 1'b0;
      prio_win = 1'b0;
      winner   = '0;
      idx      = '0;
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
         idx = PtrW'((32'(rr_ptr_q) + k) % REQ_NUM);
         if (!found && bus.fu_req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
`ifdef CDB_ARB_BPU_PRIO_EN
      if (bus.fu_req[BpuIdx]) begin
         found    = 1'b1;
         prio_win = 1'b1;
         winner   = BpuIdx;
      end
`endif
      // Flush suppresses the grant entirely; the requester simply retries later.
      grant = found & ~bus.rob_flush;
   end

   // One-hot grant and payload mux for the selected requester.
   always_comb begin
      gnt        = '0;
      win_rob_id = '0;
      win_data   = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (winner == PtrW'(i)) begin
            gnt[i]     = grant;
            win_rob_id = bus.fu_rob_id[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
            win_data   = bus.fu_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Pointer advance and broadcast stage next-state.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = grant;
      cdb_src_d    = gnt;
      cdb_rob_id_d = cdb_rob_id_q;
      cdb_data_d   = cdb_data_q;
      if (grant) begin
         cdb_rob_id_d = win_rob_id;
         cdb_data_d   = win_data;
         // A BPU priority win leaves fairness state untouched for the others.
         if (!prio_win) begin
            rr_ptr_d = (winner == PtrW'(REQ_NUM - 1)) ? '0 : winner + PtrW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_rob_id_q <= '0;
         cdb_data_q   <= '0;
         cdb_src_q    <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_rob_id_q <= cdb_rob_id_d;
         cdb_data_q   <= cdb_data_d;
         cdb_src_q    <= cdb_src_d;
      end
   end

   assign bus.fu_gnt     = gnt;
   assign bus.cdb_valid  = cdb_valid_q;
   assign bus.cdb_rob_id = cdb_rob_id_q;
   assign bus.cdb_data   = cdb_data_q;
   assign bus.cdb_src    = cdb_src_q;

endmodule
